// File: rtl/clock_pkg.sv
// Shared types and helpers for the PLL bring-up supervisor and its clock-domain helpers.
// The state encoding is exported on state_o, so the values are fixed.
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        CLEAR     = 3'd4,
        FAIL      = 3'd5
    } sup_state_t;

    // Width able to count up to the largest of three terminal counts; never below one bit.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-high reset.
// The pixel-domain reset path also uses it.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Bring-up sequencer and lock supervisor for the pixel-clock PLL, clocked from the 10 MHz reference.
// Qualifies lock, gates the downstream reset, counts lock losses and flags lock timeouts.
module pll_lock_supervisor
    import clock_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT    = 100000,
    parameter int unsigned STABLE_CYCLES   = 1024,
    parameter int unsigned STDY_RST_CYCLES = 2,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk_10m,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             retry,
    output logic             stdy_rst,
    output logic             dn_rst,
    output logic             clk_ok,
    output logic             fault,
    output logic [CNT_W-1:0] lost_count,
    output logic [2:0]       state_o
);

    localparam int unsigned TIMER_W = timer_width(LOCK_TIMEOUT, STABLE_CYCLES, STDY_RST_CYCLES);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CLEAR_LAST   = TIMER_W'(STDY_RST_CYCLES - 1);

    sup_state_t         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   lost_q, lost_d;
    logic               dn_rst_q, dn_rst_d;
    logic               clk_ok_q, clk_ok_d;
    logic               stdy_rst_q, stdy_rst_d;
    logic               fault_q, fault_d;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk (clk_10m),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_ff @(posedge clk_10m or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            lost_q     <= '0;
            dn_rst_q   <= 1'b1;
            clk_ok_q   <= 1'b0;
            stdy_rst_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lost_q     <= lost_d;
            dn_rst_q   <= dn_rst_d;
            clk_ok_q   <= clk_ok_d;
            stdy_rst_q <= stdy_rst_d;
            fault_q    <= fault_d;
        end
    end

    // Lock outranks the timeout in WAIT_LOCK; CLEAR runs to completion whatever lock does.
    always_comb begin
        state_d = state_q;
        lost_d  = lost_q;
        case (state_q)
            IDLE: state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s)
                    state_d = STABLE;
                else if (timer_q == TIMEOUT_LAST)
                    state_d = FAIL;
            end
            STABLE: begin
                if (!lock_s)
                    state_d = WAIT_LOCK;
                else if (timer_q == STABLE_LAST)
                    state_d = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = CLEAR;
                    if (lost_q != '1)
                        lost_d = lost_q + CNT_W'(1);
                end
            end
            CLEAR: begin
                if (timer_q == CLEAR_LAST)
                    state_d = WAIT_LOCK;
            end
            FAIL: begin
                if (retry)
                    state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_comb begin
        dn_rst_d   = (state_d != RUN);
        clk_ok_d   = (state_d == RUN);
        stdy_rst_d = (state_d == CLEAR);
        fault_d    = (state_d == FAIL);
    end

    assign stdy_rst   = stdy_rst_q;
    assign dn_rst     = dn_rst_q;
    assign clk_ok     = clk_ok_q;
    assign fault      = fault_q;
    assign lost_count = lost_q;
    assign state_o    = state_q;

endmodule
